// File: rtl/dianti_pkg.sv
// rtl/dianti_pkg.sv - shared constants for the four-floor elevator request path
package dianti_pkg;

   localparam int FLOORS = 4;

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   // LSB positions of each switch group inside key_pulse
   localparam int KP_CAR  = 0;
   localparam int KP_UP   = 4;
   localparam int KP_DOWN = 7;
   localparam int KP_W    = 10;

   function automatic logic floor_hit(input logic [2:0] fl, input int floor);
      return fl == 3'(floor);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one switch: 2-flop sync, persistence counter, debounced level, toggle pulse
module key_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic arm_i,
   input  logic raw_i,
   output logic press_o,
   output logic pulse_o
);

   localparam logic [3:0] CNT_MAX = 4'(DEB_CYCLES);

   logic       sync1_q, sync2_q;
   logic       deb_q, deb_d;
   logic [3:0] cnt_q, cnt_d;
   logic       pulse_q;

   // Early strobe lets the parent set the pending bit on the same edge the pulse registers.
   assign press_o = arm_i && (cnt_q == CNT_MAX);
   assign pulse_o = pulse_q;

   always_comb begin
      deb_d = deb_q;
      cnt_d = 4'd0;
      if (!arm_i) begin
         deb_d = sync2_q;
      end else if (press_o) begin
         deb_d = ~deb_q;
      end else if (sync2_q != deb_q) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= 4'd0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         pulse_q <= press_o;
      end
   end

endmodule

// File: rtl/hall_call_register.sv
// rtl/hall_call_register.sv - debounced car/hall call latch with service-clear for the elevator controller
module hall_call_register
   import dianti_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] kin_car,
   input  logic [2:0] kin_up,
   input  logic [2:0] kin_down,
   input  logic [2:0] fl_num,
   input  logic       door_open,
   input  logic [1:0] dir,
   output logic [3:0] car_req,
   output logic [2:0] up_req,
   output logic [2:0] down_req,
   output logic [9:0] key_pulse,
   output logic       any_req
);

   localparam logic [4:0] ARM_DONE = 5'(DEB_CYCLES + 2);

   logic [4:0]      arm_q, arm_d;
   logic            armed;
   logic [KP_W-1:0] raw, press;
   logic [3:0]      car_q, car_d;
   logic [2:0]      up_q, up_d;
   logic [2:0]      down_q, down_d;
   logic            any_q;

   assign raw   = {kin_down, kin_up, kin_car};
   assign armed = (arm_q == ARM_DONE);
   assign arm_d = armed ? arm_q : arm_q + 5'd1;

   for (genvar i = 0; i < KP_W; i++) begin : g_key
      key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
         .clk    (clk),
         .rst_n  (rst_n),
         .arm_i  (armed),
         .raw_i  (raw[i]),
         .press_o(press[i]),
         .pulse_o(key_pulse[i])
      );
   end

   // A served floor both blocks new sets and clears, so clear wins on collision.
   always_comb begin
      car_d  = car_q;
      up_d   = up_q;
      down_d = down_q;
      for (int f = 0; f < FLOORS; f++) begin
         if (door_open && floor_hit(fl_num, f + 1)) car_d[f] = 1'b0;
         else if (press[KP_CAR + f])                 car_d[f] = 1'b1;
      end
      for (int f = 0; f < FLOORS - 1; f++) begin
         if (door_open && floor_hit(fl_num, f + 1)) begin
            if (dir != DIR_DOWN) up_d[f] = 1'b0;
         end else if (press[KP_UP + f]) begin
            up_d[f] = 1'b1;
         end
         if (door_open && floor_hit(fl_num, f + 2)) begin
            if (dir != DIR_UP) down_d[f] = 1'b0;
         end else if (press[KP_DOWN + f]) begin
            down_d[f] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q  <= 5'd0;
         car_q  <= 4'd0;
         up_q   <= 3'd0;
         down_q <= 3'd0;
         any_q  <= 1'b0;
      end else begin
         arm_q  <= arm_d;
         car_q  <= car_d;
         up_q   <= up_d;
         down_q <= down_d;
         any_q  <= |{car_q, up_q, down_q};
      end
   end

   assign car_req  = car_q;
   assign up_req   = up_q;
   assign down_req = down_q;
   assign any_req  = any_q;

endmodule

// File: doc/hall_call_register.md
# hall_call_register

Front-end request stage for the four-floor elevator, sitting between the board's raw key/switch inputs and the `dianti` controller. It does the following:
- Synchronises and debounces all ten call inputs on the scan clock.
- Turns each accepted toggle into a one-cycle press pulse.
- Latches pending car and hall calls per floor, clearing them when the car serves that floor with the door open.

Its registered request vectors replace the ad-hoc edge detection and LED tracking currently done at top level.

## Interface
- `DEB_CYCLES`, default 4: consecutive clock edges a new synchronised level must persist before it is accepted (4 ≈ 21 ms at 190 Hz). Legal range 1..15.
- `clk`  in  1  scan clock (clk190hz domain); every register is clocked on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `kin_car`  in  4  raw car-panel switches; bit0 = floor 1.
- `kin_up`  in  3  raw hall UP switches, floors 1..3; bit0 = floor 1.
- `kin_down`  in  3  raw hall DOWN switches, floors 2..4; bit0 = floor 2.
- `fl_num`  in  3  current floor from the controller; legal values 1..4.
- `door_open`  in  1  controller door-open indication.
- `dir`  in  2  controller travel direction: 01 up, 10 down, 00 idle, 11 treated as idle.
- `car_req`  out  4  pending car calls.
- `up_req`  out  3  pending UP hall calls.
- `down_req`  out  3  pending DOWN hall calls.
- `key_pulse`  out  10  one-cycle accepted-press pulses, ordered {kin_down, kin_up, kin_car}.
- `any_req`  out  1  OR of all pending bits, registered.

## Operation
- **Synchronisation:** each raw input passes through a 2-flop synchroniser.
- **Debounce:**
  - Per input, a debounced level and a counter wide enough for `DEB_CYCLES`.
  - When the synchronised level differs from the debounced level, the counter increments.
  - When it is equal, the counter is cleared.
  - When the counter reaches `DEB_CYCLES`, the debounced level flips and the counter clears.
- **Press definition:** inputs are slide switches, so either edge of the debounced level is a press.
- **Arming:**
  - An arm counter is cleared by reset and counts up to `DEB_CYCLES`+2.
  - While unarmed, debounced levels load the synchronised level directly and no press is produced, so switches already on at reset do not generate calls.
- **Set:** a press on input i sets its pending bit, except when that floor equals `fl_num` and `door_open`=1; the call is already served there and the press is ignored (pulse still asserted).
- **Clear:** applies when `door_open`=1 and `fl_num`=f, for f in 1..4:
  - `car_req`[f] clears.
  - `up_req`[f] clears unless `dir`=10.
  - `down_req`[f] clears unless `dir`=01.
- **Invalid floor:** `fl_num` of 0 or 5..7 clears nothing.
- **Set/clear collision:** set and clear of the same bit in the same cycle resolves to clear. Set of one bit and clear of another proceed independently.
- **Reset values:** all outputs 0, all synchronisers, debounced levels and counters 0, unarmed.
- **Reset mid-operation:** asserting `rst_n` discards all pending calls immediately and asynchronously. After release, the block re-arms as above.

## Timing
- All outputs are registered; no combinational input-to-output path.
- **Press latency:** raw level changes and holds. The first rising edge that samples the new raw level is edge 0. `key_pulse` and the pending bit both assert after edge `DEB_CYCLES`+2, i.e. 6 edges for `DEB_CYCLES`=4.
- `key_pulse` is high for exactly one cycle per accepted toggle.
- **Clear latency:** the pending bit drops after the first edge at which `door_open`=1 and `fl_num` match.
- `any_req` lags the pending vectors by one cycle.
- **Glitch rejection:** a raw change held for fewer than `DEB_CYCLES` synchronised cycles produces no pulse and no set.
- **Arming period:** `DEB_CYCLES`+2 edges after reset release. Toggles during this period are absorbed silently.

## Structure
- Shared package `dianti_pkg` holds:
  - `FLOORS`=4
  - direction encodings `DIR_UP`=2'b01, `DIR_DOWN`=2'b10, `DIR_IDLE`=2'b00
  - `key_pulse` bit-index constants
- Sub-module `key_debounce` contains synchroniser, counter, debounced level and edge pulse, with an `arm` input. It is instantiated 10 times; the parent holds the arm counter and the request registers.

## Test plan
- Reset, then `kin_car`[2] 0→1 held, `DEB_CYCLES`=4 → `key_pulse`[2] high for one cycle and `car_req`=4'b0100 after edge 6; `any_req`=1 one cycle later.
- `kin_up`[0] high for 3 cycles then low → no pulse, `up_req` stays 3'b000.
- Pending `up_req`[1] and `down_req`[0] (both floor 2), `fl_num`=2, `door_open`=1, `dir`=01 → `up_req`[1] clears; `down_req`[0] stays 1. Then `dir`=00 → `down_req`[0] clears.
- `fl_num`=3, `door_open`=1, press `kin_car`[2] → pulse asserted, `car_req`[2] stays 0. Same press with `door_open`=0 → bit sets.
- `kin_down`[2] held high across reset release → no pulse, `down_req`=0 through arming. A later toggle to 0 → pulse and `down_req`[2]=1.
- With several calls pending, assert `rst_n`=0 mid-cycle → all outputs 0 immediately; `fl_num`=6 with `door_open`=1 → no bit clears.
